threshold_filter: RTL
=====================

# threshold_filter

Pixel-stream stage directly downstream of the image reader. It consumes the reader's two-pixel-per-clock RGB stream (even/odd pair) qualified by the vertical and horizontal sync pulses. Each pixel is binarised against a programmable threshold and emitted as a pixel pair for the image writer. The stage tracks row/column position, flags malformed rows, and raises a done flag once a full frame has been produced.

## Interface
- IMAGE_WIDTH, 768, pixels per row; must be even; pairs per row = IMAGE_WIDTH/2.
- IMAGE_HEIGHT, 512, rows per frame.
- THRESHOLD, 90, per-pixel threshold; pixel is white when R+G+B > 3*THRESHOLD.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_R_Even / data_G_Even / data_B_Even  input  8 each  even pixel channels.
- data_R_Odd / data_G_Odd / data_B_Odd  input  8 each  odd pixel channels.
- vertical_Pulse  input  1  frame start; a rising edge arms a new frame.
- horizontal_Pulse  input  1  high = the current input pair is valid.
- out_R_Even / out_G_Even / out_B_Even  output  8 each  binarised even pixel (8'hFF or 8'h00, identical on all three channels).
- out_R_Odd / out_G_Odd / out_B_Odd  output  8 each  binarised odd pixel.
- out_Valid  output  1  output pair valid this cycle.
- out_Column  output  10  pair index (0..IMAGE_WIDTH/2-1) of the current output pair.
- out_Row  output  10  row index (0..IMAGE_HEIGHT-1) of the current output pair.
- row_Error  output  1  sticky malformed-row/frame flag.
- done_Flag  output  1  frame complete.

## Operation
- FSM states:
  - IDLE: stage waits for a vertical_Pulse rising edge, then enters FRAME with row and column counters at 0.
  - FRAME: each cycle with horizontal_Pulse=1 accepts one pair.
  - DRAIN: waits until the pipeline has emitted its last pair.
  - DONE: done_Flag=1.
- Rising-edge detection uses a one-cycle registered copy of vertical_Pulse, cleared to 0 on reset.
- On each accepted pair:
  - Column increments.
  - At IMAGE_WIDTH/2-1, column wraps to 0 and row increments.
  - When the last pair of the last row is accepted (row IMAGE_HEIGHT-1, column IMAGE_WIDTH/2-1), FSM goes to DRAIN.
- Pipeline stage 1 registers the 10-bit zero-extended sums R+G+B for both pixels, plus valid, row and column.
- Pipeline stage 2 compares each sum against the constant 3*THRESHOLD, computed at elaboration with ≥10 bits, using a strict greater-than. It registers 8'hFF if the sum is greater, else 8'h00, onto all three channels.
- Boundary behaviour:
  - horizontal_Pulse falls in FRAME with column≠0 (short row): set row_Error; reset column to 0; row unchanged, so the row is re-received.
  - horizontal_Pulse=1 in IDLE, DRAIN or DONE: ignored; no output produced.
  - vertical_Pulse rising edge in FRAME: set row_Error; restart the frame with row=column=0. Pairs already in the pipeline still drain.
  - vertical_Pulse rising edge in DONE: clear done_Flag; go to FRAME with counters 0.
  - row_Error is cleared only by reset.
- Reset mid-operation: every register clears immediately, in-flight pairs are discarded, FSM goes to IDLE.

## Timing
- Reset values: all out_* data = 8'h00; out_Valid=0; out_Column=0; out_Row=0; row_Error=0; done_Flag=0; FSM=IDLE.
- Latency: a pair accepted at edge N appears on outputs with out_Valid=1 after edge N+2, i.e. fixed 2-cycle latency.
- Throughput: one pair per clock, no back-pressure.
- out_Valid follows the accepted pattern exactly, delayed 2 cycles. Outputs hold their last values when out_Valid=0.
- done_Flag rises on the edge after the last output pair's out_Valid cycle (acceptance + 3). It stays high until a vertical_Pulse rising edge or reset.
- The first pair may be accepted on the cycle after the vertical_Pulse rising edge is detected. The edge is detected one cycle after vertical_Pulse goes high.

## Test plan
- Threshold edges (defaults): even R=G=B=91 (sum 273), odd R=G=B=90 (sum 270) → out Even=8'hFF, Odd=8'h00, out_Valid exactly 2 cycles after acceptance.
- Mixed channels: R=255,G=15,B=1 (sum 271) → 8'hFF; R=0,G=0,B=255 (255) → 8'h00; R=G=B=255 (765, no overflow) → 8'hFF.
- Full small frame (IMAGE_WIDTH=8, IMAGE_HEIGHT=2), continuous horizontal_Pulse:
  - 8 outputs, out_Column 0..3 with wrap, out_Row 0 then 1.
  - done_Flag rises 3 cycles after the 8th acceptance; row_Error=0.
- Short row: horizontal_Pulse drops after 2 pairs of row 0 → row_Error=1; the next 4 pairs are labelled row 0, columns 0..3.
- Mid-frame vertical_Pulse rise and second frame: row_Error=1, counters restart at 0, done_Flag only after a full frame. A vertical_Pulse rise in DONE clears done_Flag.
- Async reset asserted while out_Valid=1: all outputs return to reset values without a clock edge. After release, no outputs until a new vertical_Pulse rising edge.

Source files
------------

// File: rtl/threshold_filter.sv
// threshold_filter: binarises a two-pixel-per-clock RGB stream against a fixed threshold.
// Tracks row/column position, flags malformed rows and signals completion of each frame.
module threshold_filter #(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned THRESHOLD    = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_R_Even,
    input  logic [7:0] data_G_Even,
    input  logic [7:0] data_B_Even,
    input  logic [7:0] data_R_Odd,
    input  logic [7:0] data_G_Odd,
    input  logic [7:0] data_B_Odd,
    input  logic       vertical_Pulse,
    input  logic       horizontal_Pulse,
    output logic [7:0] out_R_Even,
    output logic [7:0] out_G_Even,
    output logic [7:0] out_B_Even,
    output logic [7:0] out_R_Odd,
    output logic [7:0] out_G_Odd,
    output logic [7:0] out_B_Odd,
    output logic       out_Valid,
    output logic [9:0] out_Column,
    output logic [9:0] out_Row,
    output logic       row_Error,
    output logic       done_Flag
);

    localparam logic [9:0]  LastCol   = 10'(IMAGE_WIDTH / 2 - 1);
    localparam logic [9:0]  LastRow   = 10'(IMAGE_HEIGHT - 1);
    localparam logic [11:0] ThreshSum = 12'(3 * THRESHOLD);

    typedef enum logic [1:0] {StIdle, StFrame, StDrain, StDone} state_e;

    state_e     state_q, state_d;
    logic       vp_q;
    logic       vp_rise;
    logic [9:0] row_q, row_d;
    logic [9:0] col_q, col_d;
    logic       err_q, err_d;
    logic       accept;

    logic [9:0] sum_even, sum_odd;
    logic       s1_valid_q;
    logic [9:0] s1_sum_even_q, s1_sum_odd_q;
    logic [9:0] s1_row_q, s1_col_q;

    logic       out_valid_q;
    logic [7:0] out_even_q, out_odd_q;
    logic [9:0] out_row_q, out_col_q;

    assign vp_rise  = vertical_Pulse & ~vp_q;
    assign sum_even = {2'b00, data_R_Even} + {2'b00, data_G_Even} + {2'b00, data_B_Even};
    assign sum_odd  = {2'b00, data_R_Odd} + {2'b00, data_G_Odd} + {2'b00, data_B_Odd};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (vp_rise) begin
                    state_d = StFrame;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StFrame: begin
                // A new frame start overrides any pair presented in the same cycle.
                if (vp_rise) begin
                    err_d = 1'b1;
                    row_d = '0;
                    col_d = '0;
                end else if (horizontal_Pulse) begin
                    accept = 1'b1;
                    if (col_q == LastCol) begin
                        col_d = '0;
                        if (row_q == LastRow) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end else if (col_q != '0) begin
                    // Short row: restart the same row from column 0.
                    err_d = 1'b1;
                    col_d = '0;
                end
            end
            StDrain: begin
                if (!s1_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (vp_rise) begin
                    state_d = StFrame;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            vp_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vp_q    <= vertical_Pulse;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_sum_even_q <= '0;
            s1_sum_odd_q  <= '0;
            s1_row_q      <= '0;
            s1_col_q      <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_even_q <= sum_even;
                s1_sum_odd_q  <= sum_odd;
                s1_row_q      <= row_q;
                s1_col_q      <= col_q;
            end
        end
    end

    // Outputs hold their last pair whenever no new pair arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_even_q  <= '0;
            out_odd_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_even_q <= ({2'b00, s1_sum_even_q} > ThreshSum) ? 8'hFF : 8'h00;
                out_odd_q  <= ({2'b00, s1_sum_odd_q} > ThreshSum) ? 8'hFF : 8'h00;
                out_row_q  <= s1_row_q;
                out_col_q  <= s1_col_q;
            end
        end
    end

    assign out_R_Even = out_even_q;
    assign out_G_Even = out_even_q;
    assign out_B_Even = out_even_q;
    assign out_R_Odd  = out_odd_q;
    assign out_G_Odd  = out_odd_q;
    assign out_B_Odd  = out_odd_q;
    assign out_Valid  = out_valid_q;
    assign out_Column = out_col_q;
    assign out_Row    = out_row_q;
    assign row_Error  = err_q;
    assign done_Flag  = (state_q == StDone);

endmodule
